// File: rtl/peripheral_ahb3_slave_mem_if.sv
// AHB3-Lite slave bus bundle for peripheral_ahb3_slave_mem.
// Signal names follow the AMBA names so that waveforms map directly onto the bus.
interface peripheral_ahb3_slave_mem_if #(
    parameter int XLEN = 64,
    parameter int PLEN = 64
);
    logic            HSEL;
    logic [PLEN-1:0] HADDR;
    logic [XLEN-1:0] HWDATA;
    logic [XLEN-1:0] HRDATA;
    logic            HWRITE;
    logic [2:0]      HSIZE;
    logic [2:0]      HBURST;
    logic [3:0]      HPROT;
    logic [1:0]      HTRANS;
    logic            HMASTLOCK;
    logic            HREADY;
    logic            HREADYOUT;
    logic            HRESP;

    modport master (
        output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/peripheral_ahb3_slave_mem.sv
// AHB3-Lite memory slave: XLEN-wide word array with byte-lane writes, optional
// fixed wait states per OKAY transfer and a two-cycle ERROR response.
module peripheral_ahb3_slave_mem #(
    parameter int XLEN        = 64,
    parameter int PLEN        = 64,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic HCLK,
    input  logic HRESETn,
    peripheral_ahb3_slave_mem_if.slave bus
);
    localparam int BYTES = XLEN / 8;
    localparam int OFFW  = $clog2(BYTES);
    localparam int IDXW  = $clog2(DEPTH);
    localparam int AW    = OFFW + IDXW;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ERR1,
        ERR2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [2:0]      size_q, size_d;
    logic            write_q, write_d;
    logic            active_q, active_d;

    logic [XLEN-1:0] mem [DEPTH];

    logic            readyOut;
    logic            sample;
    logic            addrErr;
    logic            wrEn;
    logic [PLEN-1:0] alignMask;
    logic [BYTES-1:0] byteEn;

    assign readyOut = (state_q == IDLE) || (state_q == ERR2) ||
                      ((state_q == WAIT) && (cnt_q == 4'd0));
    assign sample   = bus.HSEL && bus.HREADY && bus.HTRANS[1];
    assign wrEn     = readyOut && active_q && write_q;

    // Out-of-range word, oversize transfer or misalignment all take the ERROR path.
    always_comb begin
        alignMask = (PLEN'(1) << bus.HSIZE) - PLEN'(1);
        addrErr   = ((bus.HADDR >> OFFW) >= PLEN'(DEPTH)) ||
                    (bus.HSIZE > 3'(OFFW)) ||
                    ((bus.HADDR & alignMask) != '0);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        size_d   = size_q;
        write_d  = write_q;
        active_d = active_q;

        case (state_q)
            ERR1:    state_d = ERR2;
            WAIT:    if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
            default: ;
        endcase

        // A completing data phase (or an idle bus) is the only point a new address phase is taken.
        if (readyOut) begin
            state_d  = IDLE;
            active_d = 1'b0;
            write_d  = 1'b0;
            if (sample) begin
                addr_d  = bus.HADDR[AW-1:0];
                size_d  = bus.HSIZE;
                write_d = bus.HWRITE;
                if (addrErr) begin
                    state_d = ERR1;
                end else begin
                    active_d = 1'b1;
                    if (WAIT_STATES != 0) begin
                        state_d = WAIT;
                        cnt_d   = 4'(WAIT_STATES);
                    end
                end
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            addr_q   <= '0;
            size_q   <= 3'd0;
            write_q  <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            write_q  <= write_d;
            active_q <= active_d;
        end
    end

    always_comb begin
        byteEn = '0;
        for (int b = 0; b < BYTES; b++) begin
            byteEn[b] = (b >= int'(addr_q[OFFW-1:0])) &&
                        (b < int'(addr_q[OFFW-1:0]) + (1 << size_q));
        end
    end

    // Storage has no reset so contents survive HRESETn; active_q gates aborted transfers.
    always_ff @(posedge HCLK) begin
        if (wrEn && HRESETn) begin
            for (int b = 0; b < BYTES; b++) begin
                if (byteEn[b]) mem[addr_q[AW-1:OFFW]][b*8 +: 8] <= bus.HWDATA[b*8 +: 8];
            end
        end
    end

    assign bus.HREADYOUT = readyOut;
    assign bus.HRESP     = (state_q == ERR1) || (state_q == ERR2);
    assign bus.HRDATA    = (readyOut && active_q && !write_q) ? mem[addr_q[AW-1:OFFW]] : '0;

endmodule

// File: tb/tb_peripheral_ahb3_slave_mem.sv
// Directed bench for peripheral_ahb3_slave_mem: one zero-wait and one two-wait instance
// share a stimulus bus; sel2 picks which one is addressed and observed.
module tb_peripheral_ahb3_slave_mem;
    localparam int XLEN  = 64;
    localparam int PLEN  = 64;
    localparam int DEPTH = 256;

    localparam logic [1:0] IDLE_T   = 2'b00;
    localparam logic [1:0] BUSY_T   = 2'b01;
    localparam logic [1:0] NONSEQ_T = 2'b10;

    logic HCLK    = 1'b0;
    logic HRESETn = 1'b0;
    always #5 HCLK = ~HCLK;

    logic            hsel   = 1'b0;
    logic            hwrite = 1'b0;
    logic            sel2   = 1'b0;
    logic [63:0]     haddr  = '0;
    logic [63:0]     hwdata = '0;
    logic [2:0]      hsize  = '0;
    logic [1:0]      htrans = IDLE_T;

    int checks   = 0;
    int failures = 0;

    peripheral_ahb3_slave_mem_if #(.XLEN(XLEN), .PLEN(PLEN)) bus0 ();
    peripheral_ahb3_slave_mem_if #(.XLEN(XLEN), .PLEN(PLEN)) bus2 ();

    logic            readyMux;
    logic            respMux;
    logic [63:0]     rdataMux;

    assign readyMux = sel2 ? bus2.HREADYOUT : bus0.HREADYOUT;
    assign respMux  = sel2 ? bus2.HRESP     : bus0.HRESP;
    assign rdataMux = sel2 ? bus2.HRDATA    : bus0.HRDATA;

    assign bus0.HSEL      = hsel & ~sel2;
    assign bus0.HADDR     = haddr;
    assign bus0.HWDATA    = hwdata;
    assign bus0.HWRITE    = hwrite;
    assign bus0.HSIZE     = hsize;
    assign bus0.HBURST    = 3'b000;
    assign bus0.HPROT     = 4'b0011;
    assign bus0.HTRANS    = htrans;
    assign bus0.HMASTLOCK = 1'b0;
    assign bus0.HREADY    = readyMux;

    assign bus2.HSEL      = hsel & sel2;
    assign bus2.HADDR     = haddr;
    assign bus2.HWDATA    = hwdata;
    assign bus2.HWRITE    = hwrite;
    assign bus2.HSIZE     = hsize;
    assign bus2.HBURST    = 3'b000;
    assign bus2.HPROT     = 4'b0011;
    assign bus2.HTRANS    = htrans;
    assign bus2.HMASTLOCK = 1'b0;
    assign bus2.HREADY    = readyMux;

    peripheral_ahb3_slave_mem #(
        .XLEN(XLEN), .PLEN(PLEN), .DEPTH(DEPTH), .WAIT_STATES(0)
    ) dut0 (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus0)
    );

    peripheral_ahb3_slave_mem #(
        .XLEN(XLEN), .PLEN(PLEN), .DEPTH(DEPTH), .WAIT_STATES(2)
    ) dut2 (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus2)
    );

    // One isolated NONSEQ transfer; returns what the data phase looked like.
    task automatic applyStimulus(input logic wr, input logic [63:0] addr, input logic [2:0] size,
                                 input logic [63:0] wdata, output logic [63:0] rdata,
                                 output int lowCycles, output logic respLow, output logic respEnd);
        @(negedge HCLK);
        hsel   = 1'b1;
        htrans = NONSEQ_T;
        hwrite = wr;
        haddr  = addr;
        hsize  = size;
        @(negedge HCLK);
        htrans    = IDLE_T;
        hwdata    = wdata;
        lowCycles = 0;
        respLow   = 1'b0;
        while (readyMux !== 1'b1 && lowCycles < 20) begin
            respLow = respLow | respMux;
            lowCycles++;
            @(negedge HCLK);
        end
        rdata   = rdataMux;
        respEnd = respMux;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({bus0.HREADYOUT, bus0.HRESP} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL reset_ctrl_ws0 got=%b exp=10", {bus0.HREADYOUT, bus0.HRESP});
        end
        checks++;
        if ({bus2.HREADYOUT, bus2.HRESP} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL reset_ctrl_ws2 got=%b exp=10", {bus2.HREADYOUT, bus2.HRESP});
        end
        checks++;
        if (bus0.HRDATA !== 64'h0 || bus2.HRDATA !== 64'h0) begin
            failures++;
            $display("[TB] FAIL reset_rdata got=%h/%h exp=0", bus0.HRDATA, bus2.HRDATA);
        end
        @(negedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
    endtask

    task automatic test_write_read();
        logic [63:0] rd;
        int          low;
        logic        rl, re;
        sel2 = 1'b0;
        applyStimulus(1'b1, 64'h10, 3'd3, 64'h1122334455667788, rd, low, rl, re);
        checks++;
        if (low != 0 || re !== 1'b0) begin
            failures++;
            $display("[TB] FAIL wr_phase got=low%0d resp%b exp=low0 resp0", low, re);
        end
        applyStimulus(1'b0, 64'h10, 3'd3, 64'h0, rd, low, rl, re);
        checks++;
        if (low != 0 || re !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rd_phase got=low%0d resp%b exp=low0 resp0", low, re);
        end
        checks++;
        if (rd !== 64'h1122334455667788) begin
            failures++;
            $display("[TB] FAIL rd_data got=%h exp=1122334455667788", rd);
        end
    endtask

    task automatic test_byte_lanes();
        logic [63:0] rd;
        int          low;
        logic        rl, re;
        sel2 = 1'b0;
        applyStimulus(1'b1, 64'h13, 3'd0, 64'hFFFFFFFFAAFFFFFF, rd, low, rl, re);
        applyStimulus(1'b0, 64'h10, 3'd3, 64'h0, rd, low, rl, re);
        checks++;
        if (rd !== 64'h11223344AA667788) begin
            failures++;
            $display("[TB] FAIL byte_write got=%h exp=11223344AA667788", rd);
        end
        applyStimulus(1'b1, 64'h16, 3'd1, 64'hBEEF5A5A5A5A5A5A, rd, low, rl, re);
        applyStimulus(1'b0, 64'h10, 3'd3, 64'h0, rd, low, rl, re);
        checks++;
        if (rd !== 64'hBEEF3344AA667788) begin
            failures++;
            $display("[TB] FAIL half_write got=%h exp=BEEF3344AA667788", rd);
        end
    endtask

    task automatic test_wait_states();
        logic [63:0] rd;
        int          low;
        logic        rl, re;
        sel2 = 1'b1;
        applyStimulus(1'b1, 64'h10, 3'd3, 64'h1122334455667788, rd, low, rl, re);
        checks++;
        if (low != 2 || rl !== 1'b0 || re !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ws_write got=low%0d resp%b%b exp=low2 resp00", low, rl, re);
        end
        applyStimulus(1'b0, 64'h10, 3'd3, 64'h0, rd, low, rl, re);
        checks++;
        if (low != 2 || rl !== 1'b0 || re !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ws_read got=low%0d resp%b%b exp=low2 resp00", low, rl, re);
        end
        checks++;
        if (rd !== 64'h1122334455667788) begin
            failures++;
            $display("[TB] FAIL ws_rdata got=%h exp=1122334455667788", rd);
        end
    endtask

    task automatic test_error();
        logic [63:0] rd;
        int          low;
        logic        rl, re;
        sel2 = 1'b0;
        @(negedge HCLK);
        hsel   = 1'b1;
        htrans = NONSEQ_T;
        hwrite = 1'b0;
        haddr  = 64'h800;
        hsize  = 3'd3;
        @(negedge HCLK);
        htrans = IDLE_T;
        checks++;
        if ({readyMux, respMux} !== 2'b01 || rdataMux !== 64'h0) begin
            failures++;
            $display("[TB] FAIL err1 got=rdy%b resp%b data%h exp=rdy0 resp1 data0", readyMux, respMux, rdataMux);
        end
        @(negedge HCLK);
        checks++;
        if ({readyMux, respMux} !== 2'b11 || rdataMux !== 64'h0) begin
            failures++;
            $display("[TB] FAIL err2 got=rdy%b resp%b data%h exp=rdy1 resp1 data0", readyMux, respMux, rdataMux);
        end
        htrans = NONSEQ_T;
        haddr  = 64'h10;
        @(negedge HCLK);
        htrans = IDLE_T;
        checks++;
        if ({readyMux, respMux} !== 2'b10 || rdataMux !== 64'hBEEF3344AA667788) begin
            failures++;
            $display("[TB] FAIL err2_next got=rdy%b resp%b data%h exp=rdy1 resp0 data=BEEF3344AA667788",
                     readyMux, respMux, rdataMux);
        end
        applyStimulus(1'b1, 64'h12, 3'd2, 64'h1234567812345678, rd, low, rl, re);
        checks++;
        if (low != 1 || rl !== 1'b1 || re !== 1'b1) begin
            failures++;
            $display("[TB] FAIL misalign got=low%0d resp%b%b exp=low1 resp11", low, rl, re);
        end
        applyStimulus(1'b0, 64'h20, 3'd4, 64'h0, rd, low, rl, re);
        checks++;
        if (low != 1 || re !== 1'b1 || rd !== 64'h0) begin
            failures++;
            $display("[TB] FAIL oversize got=low%0d resp%b data%h exp=low1 resp1 data0", low, re, rd);
        end
        applyStimulus(1'b0, 64'h10, 3'd3, 64'h0, rd, low, rl, re);
        checks++;
        if (rd !== 64'hBEEF3344AA667788) begin
            failures++;
            $display("[TB] FAIL misalign_nowrite got=%h exp=BEEF3344AA667788", rd);
        end
    endtask

    task automatic test_no_effect();
        logic [63:0] rd;
        int          low;
        logic        rl, re;
        sel2 = 1'b0;
        @(negedge HCLK);
        hsel   = 1'b1;
        hwrite = 1'b1;
        haddr  = 64'h10;
        hsize  = 3'd3;
        hwdata = 64'hDEADDEADDEADDEAD;
        htrans = BUSY_T;
        @(negedge HCLK);
        checks++;
        if ({readyMux, respMux} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL busy got=%b exp=10", {readyMux, respMux});
        end
        htrans = IDLE_T;
        @(negedge HCLK);
        checks++;
        if ({readyMux, respMux} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL idle got=%b exp=10", {readyMux, respMux});
        end
        hsel   = 1'b0;
        htrans = NONSEQ_T;
        @(negedge HCLK);
        checks++;
        if ({readyMux, respMux} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL unselected got=%b exp=10", {readyMux, respMux});
        end
        htrans = IDLE_T;
        @(negedge HCLK);
        applyStimulus(1'b0, 64'h10, 3'd3, 64'h0, rd, low, rl, re);
        checks++;
        if (rd !== 64'hBEEF3344AA667788) begin
            failures++;
            $display("[TB] FAIL no_effect_mem got=%h exp=BEEF3344AA667788", rd);
        end
    endtask

    task automatic test_back_to_back();
        sel2 = 1'b0;
        @(negedge HCLK);
        hsel   = 1'b1;
        htrans = NONSEQ_T;
        hwrite = 1'b1;
        haddr  = 64'h18;
        hsize  = 3'd3;
        @(negedge HCLK);
        hwdata = 64'h0123456789ABCDEF;
        hwrite = 1'b0;
        checks++;
        if (rdataMux !== 64'h0 || readyMux !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_wphase got=rdy%b data%h exp=rdy1 data0", readyMux, rdataMux);
        end
        @(negedge HCLK);
        htrans = IDLE_T;
        checks++;
        if (rdataMux !== 64'h0123456789ABCDEF || respMux !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_read got=%h resp%b exp=0123456789ABCDEF resp0", rdataMux, respMux);
        end
    endtask

    task automatic test_reset_during_wait();
        logic [63:0] rd;
        int          low;
        logic        rl, re;
        sel2 = 1'b1;
        @(negedge HCLK);
        hsel   = 1'b1;
        htrans = NONSEQ_T;
        hwrite = 1'b1;
        haddr  = 64'h10;
        hsize  = 3'd3;
        @(negedge HCLK);
        htrans = IDLE_T;
        hwdata = 64'hCAFEF00DDEADBEEF;
        checks++;
        if (readyMux !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rst_pre_wait got=%b exp=0", readyMux);
        end
        HRESETn = 1'b0;
        #1;
        checks++;
        if ({readyMux, respMux} !== 2'b10 || rdataMux !== 64'h0) begin
            failures++;
            $display("[TB] FAIL rst_in_wait got=rdy%b resp%b data%h exp=rdy1 resp0 data0", readyMux, respMux, rdataMux);
        end
        @(negedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
        applyStimulus(1'b0, 64'h10, 3'd3, 64'h0, rd, low, rl, re);
        checks++;
        if (rd !== 64'h1122334455667788 || low != 2) begin
            failures++;
            $display("[TB] FAIL rst_nowrite got=%h low%0d exp=1122334455667788 low2", rd, low);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_wait_states();
        test_error();
        test_no_effect();
        test_back_to_back();
        test_reset_during_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/peripheral_ahb3_slave_mem.md
PERIPHERAL_AHB3_SLAVE_MEM -- requirements
Module: peripheral_ahb3_slave_mem

Interface
REQ-001 SHALL have parameter XLEN, default 64, data bus width in bits.
REQ-002 SHALL have parameter PLEN, default 64, address bus width in bits.
REQ-003 SHALL have parameter DEPTH, default 256, number of XLEN-bit memory words.
REQ-004 SHALL have parameter WAIT_STATES, default 0, extra data-phase cycles per OKAY transfer (0..15).
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 SHALL provide the following ports:
- HCLK  in  1  clock, all state on rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- HSEL  in  1  slave select.
- HADDR  in  PLEN  byte address.
- HWDATA  in  XLEN  write data, data phase.
- HRDATA  out  XLEN  read data, data phase.
- HWRITE  in  1  1=write, 0=read.
- HSIZE  in  3  transfer size, 2^HSIZE bytes.
- HBURST  in  3  burst type, ignored.
- HPROT  in  4  protection, ignored.
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HMASTLOCK  in  1  lock, ignored.
- HREADY  in  1  bus-level ready, previous transfer complete.
- HREADYOUT  out  1  this slave's ready.
- HRESP  out  1  0=OKAY, 1=ERROR.

Function
REQ-007 SHALL sample an address phase only when HSEL=1, HREADY=1 and HTRANS[1]=1 (NONSEQ/SEQ); IDLE/BUSY or HSEL=0 give a zero-wait OKAY data phase with no memory effect.
REQ-008 SHALL latch HADDR, HWRITE and HSIZE on the sampling edge for use in the data phase.
REQ-009 SHALL implement FSM states IDLE, WAIT, ERR1, ERR2.
REQ-010 IDLE: HREADYOUT=1, HRESP=0; valid OKAY transfer with WAIT_STATES=0 completes in the next cycle, else -> WAIT.
REQ-011 WAIT: HREADYOUT=0, HRESP=0, down-counter loaded with WAIT_STATES, decremented each cycle; when counter reaches 0, HREADYOUT=1 for one cycle completing transfer, then back to IDLE (or straight into next sampled transfer).
REQ-012 Error condition: word index HADDR/(XLEN/8) >= DEPTH, or 2^HSIZE > XLEN/8, or HADDR not aligned to 2^HSIZE.
REQ-013 Errored transfer -> ERR1 (HREADYOUT=0, HRESP=1) -> ERR2 (HREADYOUT=1, HRESP=1) -> IDLE; no memory write; WAIT_STATES not applied.
REQ-014 Address phase presented during ERR2 with HREADY=1 SHALL be sampled normally.
REQ-015 Write SHALL commit on the edge where HREADYOUT=1 ends its data phase; only byte lanes HADDR[log2(XLEN/8)-1:0] .. +2^HSIZE-1 updated, other lanes unchanged.
REQ-016 Read data SHALL drive the full addressed word on HRDATA while data phase HREADYOUT=1; HRDATA=0 outside read data phases and during ERR1/ERR2.
REQ-017 Read immediately following a write to the same word SHALL return the newly written bytes (no hazard).
REQ-018 Memory contents SHALL NOT be cleared by reset.

Reset
REQ-019 HRESETn=0 SHALL asynchronously force state=IDLE, counter=0, HREADYOUT=1, HRESP=0, HRDATA=0, latched write flag=0.
REQ-020 Reset asserted mid-WAIT or mid-ERR1 SHALL abort the transfer with no memory write; first post-reset cycle SHALL be IDLE.

Verification
- WAIT_STATES=0: NONSEQ write 0x1122334455667788 to 0x10, HSIZE=3, then read 0x10 -> HREADYOUT=1 each data phase, HRDATA=0x1122334455667788, HRESP=0.
- Byte write 0xAA to 0x13, HSIZE=0, then read 0x10 -> HRDATA=0x11223344AA667788.
- WAIT_STATES=2: read 0x10 -> HREADYOUT low exactly 2 cycles, then high with data, HRESP=0.
- Read 0x800 with DEPTH=256 -> ERR1 (HREADYOUT=0,HRESP=1), ERR2 (HREADYOUT=1,HRESP=1), back-to-back NONSEQ in ERR2 serviced OKAY.
- HSIZE=2 write at 0x12 (misaligned) -> two-cycle ERROR, word 0x10 unchanged on readback.
- HTRANS=BUSY/IDLE with HSEL=1, and NONSEQ with HSEL=0 -> HREADYOUT=1, HRESP=0, no memory change; reset asserted during WAIT -> HREADYOUT=1 immediately, no write committed.
